// File: rtl/jtframe_lfbuf_ddr_line_pkg.sv
// Shared definitions for the core-side DDR line buffer: request FSM encoding
// and pixel half-select helpers.
package jtframe_lfbuf_ddr_line_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_REARM = 2'd2
  } state_e;

  // ln_addr[0] value that selects the low 16 bits of a 32-bit word
  localparam logic HALF_LO = 1'b0;

  function automatic logic [1:0] half_we(input logic we, input logic sel);
    logic [1:0] r;
    r = '0;
    if (we) r = (sel == HALF_LO) ? 2'b01 : 2'b10;
    return r;
  endfunction

endpackage

// File: rtl/jtframe_lfbuf_ddr_line_bank.sv
// One bank of the line buffer: 32-bit words, per-half write enable,
// zero-latency read port.
module jtframe_lfbuf_ddr_bank #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [1:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:2**AW-1];

  always_ff @(posedge clk) begin
    if (we[0]) mem[waddr][15:0]  <= wdata[15:0];
    if (we[1]) mem[waddr][31:16] <= wdata[31:16];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jtframe_lfbuf_ddr_line.sv
// Double-banked line buffer between the game core and the DDR frame-buffer
// controller, with line-ready request handshake and line counter.
module jtframe_lfbuf_ddr_line
  import jtframe_lfbuf_ddr_line_pkg::*;
#(
  parameter int            VW     = 8,
  parameter int            HW     = 9,
  parameter logic [VW-1:0] VSTART = '0,
  parameter logic [15:0]   CLRV   = 16'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          ln_hs,
  input  logic [HW-1:0] ln_addr,
  input  logic [15:0]   ln_data,
  input  logic          ln_we,
  output logic          ln_done,
  output logic [VW-1:0] ln_v,
  output logic          ln_ovr,
  input  logic          line,
  input  logic [HW-2:0] fb_addr,
  output logic [31:0]   fb_din,
  input  logic          fb_clr,
  input  logic          fb_done
);

  localparam int AW = HW - 1;

  logic [1:0]    core_we, clr_we;
  logic [31:0]   core_wd, clr_wd;
  logic [AW-1:0] core_wa;
  logic [1:0]    we0, we1;
  logic [AW-1:0] wa0, wa1;
  logic [31:0]   wd0, wd1, rd0, rd1;

  assign core_we = half_we(ln_we, ln_addr[0]);
  assign core_wd = {ln_data, ln_data};
  assign core_wa = ln_addr[HW-1:1];
  assign clr_we  = fb_clr ? 2'b11 : 2'b00;
  assign clr_wd  = {CLRV, CLRV};

  // Core owns bank[line], controller owns bank[~line]; never the same bank.
  always_comb begin
    we0 = core_we;
    wa0 = core_wa;
    wd0 = core_wd;
    we1 = clr_we;
    wa1 = fb_addr;
    wd1 = clr_wd;
    if (line) begin
      we0 = clr_we;
      wa0 = fb_addr;
      wd0 = clr_wd;
      we1 = core_we;
      wa1 = core_wa;
      wd1 = core_wd;
    end
  end

  jtframe_lfbuf_ddr_bank #(.AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (wa0),
    .wdata (wd0),
    .raddr (fb_addr),
    .rdata (rd0)
  );

  jtframe_lfbuf_ddr_bank #(.AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (wa1),
    .wdata (wd1),
    .raddr (fb_addr),
    .rdata (rd1)
  );

  assign fb_din = line ? rd0 : rd1;

  state_e        state_q, state_d;
  logic          hs_q, vs_q;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [VW-1:0] ln_v_q, ln_v_d;
  logic          ln_ovr_q, ln_ovr_d;
  logic          ln_done_q, ln_done_d;
  logic          hs_rise, vs_rise;

  assign hs_rise = ln_hs & ~hs_q;
  assign vs_rise = vs & ~vs_q;

  always_comb begin
    state_d  = state_q;
    vcnt_d   = vcnt_q;
    ln_v_d   = ln_v_q;
    ln_ovr_d = ln_ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_rise) begin
          ln_v_d  = vcnt_q;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (fb_done && hs_rise) begin
          ln_v_d  = vcnt_q;
          state_d = ST_REARM;
        end else if (fb_done) begin
          state_d = ST_IDLE;
        end else if (hs_rise) begin
          ln_ovr_d = 1'b1;
        end
      end
      ST_REARM: begin
        if (hs_rise) ln_ovr_d = 1'b1;
        state_d = ST_PEND;
      end
      default: state_d = ST_IDLE;
    endcase
    if (hs_rise) vcnt_d = vcnt_q + 1'b1;
    // vs is applied after ln_hs so a coincident edge still reports the old line
    if (vs_rise) begin
      vcnt_d   = VSTART;
      ln_ovr_d = 1'b0;
    end
    ln_done_d = (state_d == ST_PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      vcnt_q    <= VSTART;
      ln_v_q    <= VSTART;
      ln_ovr_q  <= 1'b0;
      ln_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs_q      <= ln_hs;
      vs_q      <= vs;
      vcnt_q    <= vcnt_d;
      ln_v_q    <= ln_v_d;
      ln_ovr_q  <= ln_ovr_d;
      ln_done_q <= ln_done_d;
    end
  end

  assign ln_done = ln_done_q;
  assign ln_v    = ln_v_q;
  assign ln_ovr  = ln_ovr_q;

endmodule

// File: tb/tb_jtframe_lfbuf_ddr_line.sv
// Directed bench for jtframe_lfbuf_ddr_line with VSTART=16 and CLRV=0xC3A5.
module tb_jtframe_lfbuf_ddr_line;

  localparam int          VW     = 8;
  localparam int          HW     = 9;
  localparam logic [7:0]  VSTART = 8'd16;
  localparam logic [15:0] CLRV   = 16'hC3A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs, ln_hs, ln_we, line, fb_clr, fb_done;
  logic [8:0]  ln_addr;
  logic [15:0] ln_data;
  logic [7:0]  fb_addr;
  logic        ln_done, ln_ovr;
  logic [7:0]  ln_v;
  logic [31:0] fb_din;

  int checks = 0;
  int failures = 0;

  jtframe_lfbuf_ddr_line #(
    .VW     (VW),
    .HW     (HW),
    .VSTART (VSTART),
    .CLRV   (CLRV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vs      (vs),
    .ln_hs   (ln_hs),
    .ln_addr (ln_addr),
    .ln_data (ln_data),
    .ln_we   (ln_we),
    .ln_done (ln_done),
    .ln_v    (ln_v),
    .ln_ovr  (ln_ovr),
    .line    (line),
    .fb_addr (fb_addr),
    .fb_din  (fb_din),
    .fb_clr  (fb_clr),
    .fb_done (fb_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hs_pulse();
    @(negedge clk) ln_hs = 1'b1;
    @(negedge clk) ln_hs = 1'b0;
  endtask

  task automatic done_pulse();
    @(negedge clk) fb_done = 1'b1;
    @(negedge clk) fb_done = 1'b0;
  endtask

  task automatic vs_pulse();
    @(negedge clk) vs = 1'b1;
    @(negedge clk) vs = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vs = 1'b1; ln_hs = 1'b1; ln_we = 1'b0; line = 1'b0;
    fb_clr = 1'b0; fb_done = 1'b0; ln_addr = '0; ln_data = '0; fb_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ln_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", ln_done); end
    checks++;
    if (ln_v !== VSTART) begin failures++; $display("FAIL reset_v: got %0d want %0d", ln_v, VSTART); end
    checks++;
    if (ln_ovr !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b want 0", ln_ovr); end
    vs = 1'b0; ln_hs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ram();
    line = 1'b0;
    ln_we = 1'b1; ln_addr = 9'd4; ln_data = 16'h1111;
    @(negedge clk) begin ln_addr = 9'd5; ln_data = 16'h2222; end
    @(negedge clk) begin ln_we = 1'b0; line = 1'b1; fb_addr = 8'd2; end
    #1;
    checks++;
    if (fb_din !== 32'h22221111) begin failures++; $display("FAIL ram_pair: got %h want 22221111", fb_din); end
    @(negedge clk) begin line = 1'b0; ln_we = 1'b1; ln_addr = 9'd4; ln_data = 16'h4444; end
    @(negedge clk) begin ln_we = 1'b0; line = 1'b1; end
    #1;
    checks++;
    if (fb_din !== 32'h22224444) begin failures++; $display("FAIL ram_half_keep: got %h want 22224444", fb_din); end
    @(negedge clk) line = 1'b0;
  endtask

  task automatic test_lines();
    vs_pulse();
    for (int i = 0; i < 3; i++) begin
      hs_pulse();
      checks++;
      if (ln_done !== 1'b1) begin failures++; $display("FAIL line%0d_done: got %b want 1", i, ln_done); end
      checks++;
      if (ln_v !== VSTART + 8'(i)) begin failures++; $display("FAIL line%0d_v: got %0d want %0d", i, ln_v, VSTART + 8'(i)); end
      done_pulse();
      checks++;
      if (ln_done !== 1'b0) begin failures++; $display("FAIL line%0d_ack: got %b want 0", i, ln_done); end
    end
    checks++;
    if (ln_ovr !== 1'b0) begin failures++; $display("FAIL lines_ovr: got %b want 0", ln_ovr); end
  endtask

  task automatic test_overrun();
    hs_pulse();
    hs_pulse();
    checks++;
    if (ln_done !== 1'b1) begin failures++; $display("FAIL ovr_done: got %b want 1", ln_done); end
    checks++;
    if (ln_v !== VSTART + 8'd3) begin failures++; $display("FAIL ovr_v: got %0d want %0d", ln_v, VSTART + 8'd3); end
    checks++;
    if (ln_ovr !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b want 1", ln_ovr); end
    vs_pulse();
    checks++;
    if (ln_ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b want 0", ln_ovr); end
    checks++;
    if (ln_done !== 1'b1) begin failures++; $display("FAIL ovr_still_pend: got %b want 1", ln_done); end
    done_pulse();
    checks++;
    if (ln_done !== 1'b0) begin failures++; $display("FAIL ovr_ack: got %b want 0", ln_done); end
  endtask

  task automatic test_back_to_back();
    hs_pulse();
    checks++;
    if (ln_v !== VSTART) begin failures++; $display("FAIL b2b_first_v: got %0d want %0d", ln_v, VSTART); end
    @(negedge clk) begin fb_done = 1'b1; ln_hs = 1'b1; end
    @(negedge clk) begin fb_done = 1'b0; ln_hs = 1'b0; end
    checks++;
    if (ln_done !== 1'b0) begin failures++; $display("FAIL b2b_rearm_low: got %b want 0", ln_done); end
    @(negedge clk);
    checks++;
    if (ln_done !== 1'b1) begin failures++; $display("FAIL b2b_rearm_high: got %b want 1", ln_done); end
    checks++;
    if (ln_v !== VSTART + 8'd1) begin failures++; $display("FAIL b2b_v: got %0d want %0d", ln_v, VSTART + 8'd1); end
    checks++;
    if (ln_ovr !== 1'b0) begin failures++; $display("FAIL b2b_ovr: got %b want 0", ln_ovr); end
    done_pulse();
  endtask

  task automatic test_clear();
    line = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk) begin
        fb_clr = 1'b1; fb_addr = 8'(k);
        ln_we = 1'b1; ln_addr = 9'(k); ln_data = 16'h6000 + 16'(k);
      end
    end
    @(negedge clk) begin fb_clr = 1'b0; ln_we = 1'b0; end
    for (int w = 0; w < 256; w++) begin
      fb_addr = 8'(w);
      #1;
      checks++;
      if (fb_din !== {CLRV, CLRV}) begin
        failures++; $display("FAIL clr_bank0[%0d]: got %h want %h", w, fb_din, {CLRV, CLRV});
      end
    end
    @(negedge clk) line = 1'b0;
    for (int w = 0; w < 128; w++) begin
      logic [31:0] exp;
      exp = {16'h6000 + 16'(2*w + 1), 16'h6000 + 16'(2*w)};
      fb_addr = 8'(w);
      #1;
      checks++;
      if (fb_din !== exp) begin failures++; $display("FAIL clr_bank1[%0d]: got %h want %h", w, fb_din, exp); end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap_and_reset();
    vs_pulse();
    hs_pulse();
    for (int i = 0; i < 238; i++) hs_pulse();
    done_pulse();
    hs_pulse();
    checks++;
    if (ln_v !== 8'd255) begin failures++; $display("FAIL wrap_255: got %0d want 255", ln_v); end
    done_pulse();
    hs_pulse();
    checks++;
    if (ln_v !== 8'd0) begin failures++; $display("FAIL wrap_0: got %0d want 0", ln_v); end
    done_pulse();
    @(negedge clk) begin vs = 1'b1; ln_hs = 1'b1; end
    @(negedge clk) begin vs = 1'b0; ln_hs = 1'b0; end
    checks++;
    if (ln_v !== 8'd1) begin failures++; $display("FAIL vs_hs_old_v: got %0d want 1", ln_v); end
    checks++;
    if (ln_ovr !== 1'b0) begin failures++; $display("FAIL vs_hs_ovr: got %b want 0", ln_ovr); end
    done_pulse();
    hs_pulse();
    checks++;
    if (ln_v !== VSTART) begin failures++; $display("FAIL vs_hs_restart: got %0d want %0d", ln_v, VSTART); end
    hs_pulse();
    checks++;
    if (ln_ovr !== 1'b1 || ln_done !== 1'b1) begin
      failures++; $display("FAIL pre_reset: got ovr=%b done=%b want 1 1", ln_ovr, ln_done);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ln_done !== 1'b0) begin failures++; $display("FAIL async_rst_done: got %b want 0", ln_done); end
    checks++;
    if (ln_v !== VSTART) begin failures++; $display("FAIL async_rst_v: got %0d want %0d", ln_v, VSTART); end
    checks++;
    if (ln_ovr !== 1'b0) begin failures++; $display("FAIL async_rst_ovr: got %b want 0", ln_ovr); end
    @(negedge clk) rst_n = 1'b1;
    hs_pulse();
    checks++;
    if (ln_v !== VSTART || ln_done !== 1'b1) begin
      failures++; $display("FAIL post_rst_line: got v=%0d done=%b want %0d 1", ln_v, ln_done, VSTART);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_lines();
    test_overrun();
    test_back_to_back();
    test_clear();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
